// File: rtl/counter_pkg.sv
// Shared types and parameter range checks for the up/down counter family.
package counter_pkg;

  // Runtime behaviour at the count bounds.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  function automatic bit width_ok(input int width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

  // The highest count must be representable in the count register.
  function automatic bit max_ok(input int width, input int max_val);
    return (max_val >= 0) && (max_val < (1 << width));
  endfunction

  // A step of zero never moves; a step above MAX would skip the whole range.
  function automatic bit step_ok(input int max_val, input int step);
    return (step >= 1) && (step <= max_val);
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// One-flop rising-edge detector used to qualify a slow enable input.
module edge_rise_det (
  input  logic clkpulse,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  // The flop remembers "d was low last cycle" rather than d itself, so reset
  // clears it to 0 and a level already high at reset release never counts.
  logic low_seen_q;
  logic low_seen_d;

  // Next history is simply the inverted input.
  always_comb begin
    low_seen_d = ~d;
  end

  // History register with synchronous active-low reset.
  always_ff @(posedge clkpulse) begin
    if (!rst) begin
      low_seen_q <= 1'b0;
    end else begin
      low_seen_q <= low_seen_d;
    end
  end

  assign pulse = d & low_seen_q;

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate mode, load, clear,
// terminal-count pulse and sticky overflow flag.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX     = 15,
  parameter int STEP    = 1,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic             clkpulse,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  mode_e            mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Reject impossible parameter sets while elaborating.
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("updown_counter_param: WIDTH out of range 2..16");
  end
  if (!max_ok(WIDTH, MAX)) begin : g_bad_max
    $error("updown_counter_param: MAX does not fit in WIDTH bits");
  end
  if (!step_ok(MAX, STEP)) begin : g_bad_step
    $error("updown_counter_param: STEP must be in 1..MAX");
  end

  // One extra bit so sums past MAX are compared before any truncation.
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH + 1)'(MAX + 1);
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_qual;
  logic [WIDTH:0]   count_w;
  logic [WIDTH:0]   next_w;

  if (EDGE_EN) begin : g_edge
    edge_rise_det u_edge (
      .clkpulse (clkpulse),
      .rst      (rst),
      .d        (en),
      .pulse    (step_qual)
    );
  end else begin : g_level
    assign step_qual = en;
  end

  // Next-state: clear beats load beats a counting step; tc is a one-cycle pulse.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    count_w = {1'b0, count_q};
    next_w  = count_w;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = ({1'b0, load_val} > MAX_W) ? MAX_C : load_val;
    end else if (step_qual) begin
      if (up) begin
        if (count_w + STEP_W <= MAX_W) begin
          next_w = count_w + STEP_W;
        end else begin
          tc_d   = 1'b1;
          ovf_d  = 1'b1;
          next_w = (mode == MODE_SAT) ? MAX_W : (count_w + STEP_W - MOD_W);
        end
      end else begin
        if (count_w >= STEP_W) begin
          next_w = count_w - STEP_W;
        end else begin
          tc_d   = 1'b1;
          ovf_d  = 1'b1;
          next_w = (mode == MODE_SAT) ? '0 : (count_w + MOD_W - STEP_W);
        end
      end
      count_d = next_w[WIDTH-1:0];
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clkpulse) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations driven in parallel
// and compared every cycle against an arithmetic reference model.
module tb_updown_counter_param;
  import counter_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  mode_e      mode;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] count_a, count_b, count_c;
  logic       tc_a, tc_b, tc_c;
  logic       ovf_a, ovf_b, ovf_c;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: 0 = STEP1, 1 = STEP3, 2 = edge-enabled.
  localparam int P_MAX  [3] = '{9, 9, 9};
  localparam int P_STEP [3] = '{1, 3, 1};
  localparam int P_EDGE [3] = '{0, 0, 1};
  int m_cnt [3];
  int m_tc  [3];
  int m_ovf [3];
  bit m_prev_en [3];

  updown_counter_param #(.WIDTH(4), .MAX(9), .STEP(1), .EDGE_EN(1'b0)) u_a (
    .clkpulse(clk), .rst(rst), .en(en), .up(up), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val), .count(count_a), .tc(tc_a), .ovf(ovf_a)
  );

  updown_counter_param #(.WIDTH(4), .MAX(9), .STEP(3), .EDGE_EN(1'b0)) u_b (
    .clkpulse(clk), .rst(rst), .en(en), .up(up), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val), .count(count_b), .tc(tc_b), .ovf(ovf_b)
  );

  updown_counter_param #(.WIDTH(4), .MAX(9), .STEP(1), .EDGE_EN(1'b1)) u_c (
    .clkpulse(clk), .rst(rst), .en(en), .up(up), .mode(mode), .clr(clr),
    .load(load), .load_val(load_val), .count(count_c), .tc(tc_c), .ovf(ovf_c)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Model one clock edge from the counter's rules using plain integer arithmetic.
  // After reset the enable is treated as already high, so only a fresh press counts.
  task automatic modelUpdate();
    for (int i = 0; i < 3; i++) begin
      int n;
      bit q;
      if (!rst) begin
        m_cnt[i] = 0;
        m_tc[i] = 0;
        m_ovf[i] = 0;
        m_prev_en[i] = 1'b1;
      end else begin
        q = (P_EDGE[i] != 0) ? (en && !m_prev_en[i]) : en;
        m_prev_en[i] = en;
        m_tc[i] = 0;
        if (clr) begin
          m_cnt[i] = 0;
          m_ovf[i] = 0;
        end else if (load) begin
          m_cnt[i] = (int'(load_val) > P_MAX[i]) ? P_MAX[i] : int'(load_val);
        end else if (q) begin
          n = up ? m_cnt[i] + P_STEP[i] : m_cnt[i] - P_STEP[i];
          if (n < 0 || n > P_MAX[i]) begin
            m_tc[i] = 1;
            m_ovf[i] = 1;
            if (mode == MODE_SAT) n = (n < 0) ? 0 : P_MAX[i];
            else n = ((n % (P_MAX[i] + 1)) + (P_MAX[i] + 1)) % (P_MAX[i] + 1);
          end
          m_cnt[i] = n;
        end
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("A.count", int'(count_a), m_cnt[0]);
    checkOutput("A.tc",    int'(tc_a),    m_tc[0]);
    checkOutput("A.ovf",   int'(ovf_a),   m_ovf[0]);
    checkOutput("B.count", int'(count_b), m_cnt[1]);
    checkOutput("B.tc",    int'(tc_b),    m_tc[1]);
    checkOutput("B.ovf",   int'(ovf_b),   m_ovf[1]);
    checkOutput("C.count", int'(count_c), m_cnt[2]);
    checkOutput("C.tc",    int'(tc_c),    m_tc[2]);
    checkOutput("C.ovf",   int'(ovf_c),   m_ovf[2]);
  endtask

  // Hold the current inputs for a number of edges, checking after each one.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      modelUpdate();
      #1;
      compareAll();
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; up = 1'b1; mode = MODE_WRAP;
    clr = 1'b0; load = 1'b0; load_val = 4'd0;

    // Reset held with en high keeps everything at zero.
    applyStimulus(2);
    checkOutput("rst_hold_count", int'(count_a), 0);

    // Count to 5, then a single reset edge mid-run.
    rst = 1'b1;
    applyStimulus(5);
    checkOutput("run_to_5", int'(count_a), 5);
    checkOutput("edge_no_step_after_release", int'(count_c), 0);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("midrun_rst_count", int'(count_a), 0);
    checkOutput("midrun_rst_ovf", int'(ovf_a), 0);
    rst = 1'b1;

    // Wrap upward through 9 -> 0, then down through 0 -> 9.
    applyStimulus(9);
    checkOutput("wrap_reach_9", int'(count_a), 9);
    checkOutput("wrap_no_tc_at_9", int'(tc_a), 0);
    applyStimulus(1);
    checkOutput("wrap_up_count", int'(count_a), 0);
    checkOutput("wrap_up_tc", int'(tc_a), 1);
    checkOutput("wrap_up_ovf", int'(ovf_a), 1);
    up = 1'b0;
    applyStimulus(1);
    checkOutput("wrap_down_count", int'(count_a), 9);
    checkOutput("wrap_down_tc", int'(tc_a), 1);

    // Saturation at both ends, tc re-pulsing while held.
    mode = MODE_SAT; load = 1'b1; load_val = 4'd8;
    applyStimulus(1);
    load = 1'b0; up = 1'b1;
    applyStimulus(3);
    checkOutput("sat_up_count", int'(count_a), 9);
    checkOutput("sat_up_tc_repulse", int'(tc_a), 1);
    load = 1'b1; load_val = 4'd1;
    applyStimulus(1);
    load = 1'b0; up = 1'b0;
    applyStimulus(2);
    checkOutput("sat_down_count", int'(count_a), 0);
    checkOutput("sat_down_tc_repulse", int'(tc_a), 1);

    // Load beats counting and clamps; clear beats load.
    load = 1'b1; load_val = 4'd12; en = 1'b1;
    applyStimulus(1);
    checkOutput("load_clamp_count", int'(count_a), 9);
    checkOutput("load_tc", int'(tc_a), 0);
    clr = 1'b1;
    applyStimulus(1);
    checkOutput("clr_over_load_count", int'(count_a), 0);
    checkOutput("clr_over_load_ovf", int'(ovf_a), 0);
    clr = 1'b0; load = 1'b0;

    // STEP=3 wrapping in both directions, then clear.
    mode = MODE_WRAP; load = 1'b1; load_val = 4'd8;
    applyStimulus(1);
    load = 1'b0; up = 1'b1;
    applyStimulus(1);
    checkOutput("step3_up_count", int'(count_b), 1);
    checkOutput("step3_up_tc", int'(tc_b), 1);
    up = 1'b0;
    applyStimulus(1);
    checkOutput("step3_down_count", int'(count_b), 8);
    checkOutput("step3_down_tc", int'(tc_b), 1);
    clr = 1'b1;
    applyStimulus(1);
    checkOutput("step3_clr_ovf", int'(ovf_b), 0);
    clr = 1'b0;

    // Edge-qualified enable: held level across reset, then one press.
    up = 1'b1; en = 1'b1; rst = 1'b0;
    applyStimulus(2);
    rst = 1'b1;
    applyStimulus(5);
    checkOutput("edge_held_no_step", int'(count_c), 0);
    en = 1'b0;
    applyStimulus(1);
    en = 1'b1;
    applyStimulus(5);
    checkOutput("edge_one_step", int'(count_c), 1);

    // Randomized traffic with occasional reset, clear and load.
    for (int k = 0; k < 600; k++) begin
      rst      = ($urandom_range(0, 49) != 0);
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 14) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 2) != 0);
      mode     = ($urandom_range(0, 1) != 0) ? MODE_SAT : MODE_WRAP;
      applyStimulus(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
